spi_write_controller: RTL and testbench

SPI controller (initiator) that generates the 16-bit register-write frames consumed by the onboarding SPI peripheral in tt_um_uwasic_onboarding_oliad. It accepts {rw, addr, data} requests on a valid/ready handshake and serialises each one as a mode-0 frame on sclk/ncs/copi, driving the peripheral's ui_in pins. It is used as the stimulus engine in integration benches and as a reusable on-chip controller.

---
 rtl/spi_write_controller.sv | 150 +++++++++++++++
 tb/tb_spi_write_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_controller.sv
// SPI mode-0 write-frame initiator: takes {rw, addr, data} requests on a
// valid/ready handshake and shifts each one out MSB first as a 16-bit frame
// on sclk/ncs/copi, with programmable chip-select setup, hold and idle gaps.
module spi_write_controller #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_IDLE     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic       busy,
  output logic       done
);

  localparam int MAX_A   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Terminal counts for each timed phase. The IDLE cycle that carries the
  // next accept is part of the inter-frame gap, so GAP itself is one shorter.
  localparam logic [CW-1:0] HP_LAST    = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_IDLE - 2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shift_q, shift_d;
  logic            sclk_q, sclk_d;
  logic            ncs_q, ncs_d;
  logic            copi_q, copi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  assign req_ready = (state_q == IDLE) & ena;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  assign copi      = copi_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // State and output registers; reset drops the frame and releases ncs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: phase sequencing, sclk toggling and bit shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid && req_ready) begin
          shift_d = {req_rw, req_addr, req_data};
          copi_d  = req_rw;
          bit_d   = 4'd15;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == HP_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: the only point where copi may change.
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 4'd1;
              shift_d = {shift_q[14:0], 1'b0};
              copi_d  = shift_q[14];
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          ncs_d   = 1'b1;
          busy_d  = 1'b0;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = (CS_IDLE > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_write_controller.sv
// Directed bench for spi_write_controller: one default instance and one with
// HALF_PERIOD=1, an SPI frame decoder per instance and a write-register model
// standing in for the onboarding peripheral.
module tb_spi_write_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] ena, req_valid, req_ready, req_rw;
  logic [6:0] req_addr [2];
  logic [7:0] req_data [2];
  logic [1:0] sclk, ncs, copi, busy, done;

  int total = 0;
  int bad = 0;

  spi_write_controller dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena[0]), .req_valid(req_valid[0]),
    .req_ready(req_ready[0]), .req_rw(req_rw[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0]),
    .busy(busy[0]), .done(done[0])
  );

  spi_write_controller #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena[1]), .req_valid(req_valid[1]),
    .req_ready(req_ready[1]), .req_rw(req_rw[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1]),
    .busy(busy[1]), .done(done[1])
  );

  initial forever #5 clk = ~clk;

  // Monitor state (per instance)
  int          cyc = 0;
  int          acc_cnt [2], acc_last [2], acc_prev [2];
  int          frames [2], edges [2], low_cnt [2], hi_cnt [2];
  int          last_low [2], last_hi [2], last_bits [2];
  int          per_cnt [2], per_min [2], per_max [2], done_cyc [2], writes [2];
  logic [15:0] sh [2];
  logic [15:0] last_frame [2];
  logic [15:0] frame_log [2][32];
  logic [7:0]  regs [2][128];
  logic [1:0]  ncs_prev = 2'b11;
  logic [1:0]  sclk_prev = 2'b00;

  // Accept log, sampled on the same edge the DUT uses.
  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0; acc_last[i] = 0; acc_prev[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_prev[i] = acc_last[i];
          acc_last[i] = cyc;
          acc_cnt[i]++;
        end
      end
    end
  end

  // Frame decoder and peripheral model, sampling on the falling clk edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      frames[i] = 0; edges[i] = 0; low_cnt[i] = 0; hi_cnt[i] = 0;
      last_low[i] = 0; last_hi[i] = 0; last_bits[i] = 0; per_cnt[i] = 0;
      per_min[i] = 0; per_max[i] = 0; done_cyc[i] = 0; writes[i] = 0;
      sh[i] = '0; last_frame[i] = '0;
      for (int a = 0; a < 128; a++) regs[i][a] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done[i]) done_cyc[i]++;
        if (!ncs[i]) begin
          if (ncs_prev[i]) begin
            last_hi[i] = hi_cnt[i];
            low_cnt[i] = 0; edges[i] = 0; sh[i] = '0;
            per_cnt[i] = 0; per_min[i] = 1000; per_max[i] = 0;
          end
          low_cnt[i]++;
          per_cnt[i]++;
          if (sclk[i] && !sclk_prev[i]) begin
            sh[i] = {sh[i][14:0], copi[i]};
            if (edges[i] > 0) begin
              if (per_cnt[i] < per_min[i]) per_min[i] = per_cnt[i];
              if (per_cnt[i] > per_max[i]) per_max[i] = per_cnt[i];
            end
            edges[i]++;
            per_cnt[i] = 0;
          end
        end else begin
          if (!ncs_prev[i]) begin
            last_frame[i] = sh[i];
            last_bits[i]  = edges[i];
            last_low[i]   = low_cnt[i];
            frame_log[i][frames[i] % 32] = sh[i];
            frames[i]++;
            hi_cnt[i] = 0;
            if (edges[i] == 16 && sh[i][15]) begin
              regs[i][sh[i][14:8]] = sh[i][7:0];
              writes[i]++;
            end
          end
          hi_cnt[i]++;
        end
      end
      ncs_prev  = ncs;
      sclk_prev = sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int i, input logic [15:0] f);
    int n;
    @(negedge clk);
    req_rw[i]    = f[15];
    req_addr[i]  = f[14:8];
    req_data[i]  = f[7:0];
    req_valid[i] = 1'b1;
    n = acc_cnt[i];
    for (int k = 0; k < 400 && acc_cnt[i] == n; k++) @(negedge clk);
    req_valid[i] = 1'b0;
    check("accept", 32'(acc_cnt[i] > n), 32'd1);
    $display("txn inst%0d frame=%h accepted at cycle %0d", i, f, acc_last[i]);
  endtask

  task automatic wait_frame(input int i, input int target);
    for (int k = 0; k < 1000 && frames[i] < target; k++) @(negedge clk);
    check("frame_done", 32'(frames[i] >= target), 32'd1);
    $display("txn inst%0d decoded=%h bits=%0d ncs_low=%0d", i, last_frame[i], last_bits[i], last_low[i]);
  endtask

  task automatic wait_edges(input int i, input int n);
    for (int k = 0; k < 1000 && !(ncs[i] == 1'b0 && edges[i] >= n); k++) @(negedge clk);
    check("edge_wait", 32'(edges[i] >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int f0, d0, n0, lowseen;

  initial begin
    ena = 2'b11; req_valid = 2'b00; req_rw = 2'b00;
    for (int i = 0; i < 2; i++) begin req_addr[i] = '0; req_data[i] = '0; end

    // Asynchronous reset between clock edges
    #7 rst_n = 1'b0;
    #1;
    check("rst_ncs",   32'(ncs[0]),  32'd1);
    check("rst_sclk",  32'(sclk[0]), 32'd0);
    check("rst_copi",  32'(copi[0]), 32'd0);
    check("rst_busy",  32'(busy[0]), 32'd0);
    check("rst_done",  32'(done[0]), 32'd0);
    check("rst_ready", 32'(req_ready[0]), 32'd1);
    ena[0] = 1'b0;
    #1 check("rst_ready_ena0", 32'(req_ready[0]), 32'd0);
    ena[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single write 0x80FF at default timing
    f0 = frames[0]; d0 = done_cyc[0];
    send(0, 16'h80FF);
    wait_frame(0, f0 + 1);
    check("w1_frame",   32'(last_frame[0]), 32'h80FF);
    check("w1_bits",    last_bits[0], 32'd16);
    check("w1_ncs_low", last_low[0],  32'd132);
    check("w1_per_min", per_min[0],   32'd8);
    check("w1_per_max", per_max[0],   32'd8);
    repeat (3) @(negedge clk);
    check("w1_done_len", done_cyc[0] - d0, 32'd1);
    check("w1_busy",     32'(busy[0]), 32'd0);
    check("w1_reg",      32'(regs[0][0]), 32'h00FF);

    // Back-to-back frames with req_valid held high
    f0 = frames[0];
    @(negedge clk);
    req_rw[0] = 1'b1; req_addr[0] = 7'h01; req_data[0] = 8'h55; req_valid[0] = 1'b1;
    n0 = acc_cnt[0];
    for (int k = 0; k < 400 && acc_cnt[0] == n0; k++) @(negedge clk);
    req_addr[0] = 7'h02; req_data[0] = 8'hAA;
    for (int k = 0; k < 400 && acc_cnt[0] == n0 + 1; k++) @(negedge clk);
    req_valid[0] = 1'b0;
    check("b2b_accepts", acc_cnt[0] - n0, 32'd2);
    check("b2b_spacing", acc_last[0] - acc_prev[0], 32'd134);
    wait_frame(0, f0 + 2);
    check("b2b_frame1", 32'(frame_log[0][f0 % 32]), 32'h8155);
    check("b2b_frame2", 32'(frame_log[0][(f0 + 1) % 32]), 32'h82AA);
    check("b2b_ncs_gap", last_hi[0], 32'd2);
    check("b2b_reg1", 32'(regs[0][1]), 32'h0055);
    check("b2b_reg2", 32'(regs[0][2]), 32'h00AA);

    // Read-bit frame on the HALF_PERIOD=1 instance
    f0 = frames[1];
    send(1, 16'h7F00);
    wait_frame(1, f0 + 1);
    check("hp1_frame",   32'(last_frame[1]), 32'h7F00);
    check("hp1_ncs_low", last_low[1], 32'd36);
    check("hp1_per_min", per_min[1],  32'd2);
    check("hp1_per_max", per_max[1],  32'd2);
    check("hp1_writes",  writes[1],   32'd0);
    check("hp1_reg7f",   32'(regs[1][127]), 32'h0000);

    // Reset after the 5th sclk rising edge, then a clean frame
    send(0, 16'h8077);
    wait_edges(0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ncs",  32'(ncs[0]),  32'd1);
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("abort_bits", last_bits[0], 32'd5);
    check("abort_reg0", 32'(regs[0][0]), 32'h00FF);
    f0 = frames[0];
    send(0, 16'h8003);
    wait_frame(0, f0 + 1);
    check("post_frame", 32'(last_frame[0]), 32'h8003);
    check("post_bits",  last_bits[0], 32'd16);
    check("post_reg0",  32'(regs[0][0]), 32'h0003);

    // ena low blocks accepts
    @(negedge clk);
    ena[0] = 1'b0;
    req_rw[0] = 1'b1; req_addr[0] = 7'h10; req_data[0] = 8'h11; req_valid[0] = 1'b1;
    n0 = acc_cnt[0]; lowseen = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ncs[0]) lowseen++;
    end
    check("ena0_accepts", acc_cnt[0] - n0, 32'd0);
    check("ena0_ncs_low", lowseen, 32'd0);
    req_valid[0] = 1'b0;
    ena[0] = 1'b1;

    // ena dropped during bit 8: frame still completes
    f0 = frames[0]; d0 = done_cyc[0];
    send(0, 16'h8142);
    wait_edges(0, 8);
    ena[0] = 1'b0;
    #1 check("ena_mid_ready", 32'(req_ready[0]), 32'd0);
    wait_frame(0, f0 + 1);
    check("ena_mid_frame", 32'(last_frame[0]), 32'h8142);
    @(negedge clk);
    req_valid[0] = 1'b1;
    n0 = acc_cnt[0];
    repeat (10) @(negedge clk);
    check("ena_mid_done",    done_cyc[0] - d0, 32'd1);
    check("ena_mid_noacc",   acc_cnt[0] - n0, 32'd0);
    check("ena_mid_ready2",  32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
